regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter DATA_W, default 32, write-data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 req0_data  input  DATA_W  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 req1_valid / req1_addr / req1_data / req1_ready  same widths, requester 1 (load unit).
REQ-010 wr_stall  input  1  register file cannot take a write this cycle.
REQ-011 wr_en  output  1  write port valid.
REQ-012 wr_addr  output  ADDR_W  write port register address.
REQ-013 wr_data  output  DATA_W  write port data.
REQ-014 wr_sel  output  1  source of the current write (0 = req0, 1 = req1); drives the address/data source mux.

Function
REQ-015 Output-stage FSM SHALL have states EMPTY (wr_en=0) and FULL (wr_en=1).
REQ-016 load_en SHALL equal (state==EMPTY) or (state==FULL and !wr_stall).
REQ-017 Transfer N SHALL occur when reqN_valid and reqN_ready are both high at a rising edge.
REQ-018 reqN_ready SHALL be high only when load_en and grant==N, and SHALL NOT depend on reqN_valid of the other requester beyond the grant rule.
REQ-019 Grant: only one valid -> that one; both valid -> the requester not equal to last_grant; none valid -> no grant.
REQ-020 last_grant SHALL update to N on every transfer N and hold otherwise.
REQ-021 On transfer, wr_addr/wr_data/wr_sel SHALL load from the winner and state SHALL go FULL next cycle (latency 1 cycle accept-to-wr_en).
REQ-022 FULL with wr_stall=1: outputs SHALL hold stable, both readys low.
REQ-023 FULL with wr_stall=0 and no transfer: state SHALL go EMPTY; with a transfer: state SHALL stay FULL with new contents (back-to-back, one write per cycle).
REQ-024 Equal addresses from both requesters SHALL be serialised in grant order; no merging.
REQ-025 In EMPTY, wr_addr/wr_data/wr_sel SHALL hold their last values.

Reset
REQ-026 reset SHALL force immediately: state=EMPTY, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, last_grant=1 (req0 wins the first tie).
REQ-027 Reset mid-operation SHALL discard a held FULL entry; readys low while reset high.

Configuration
REQ-028 Macro ZERO_REG_FILTER_EN: when defined, a valid request with addr==0 SHALL be accepted (ready=1) in the same cycle regardless of load_en or grant, SHALL NOT load the output stage, and SHALL NOT update last_grant; the other requester arbitrates as if the zero-address request were absent.
REQ-029 Without ZERO_REG_FILTER_EN, addr==0 requests SHALL be treated as ordinary writes.

Structure
REQ-030 Package regfile_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the out_state_t enum (EMPTY, FULL) and the requester-id type.
REQ-031 Grant logic SHALL be a sub-module rr_arb2 (two valids + last_grant in, one-hot grant out, combinational).

Verification
REQ-032 req0 only, addr=3, data=0xDEADBEEF at cycle 1 -> req0_ready=1 cycle 1; wr_en=1, wr_addr=3, wr_sel=0 cycle 2.
REQ-033 Both valid continuously after reset (addr 4 and 5) -> writes alternate 4,5,4,5 one per cycle starting with req0.
REQ-034 FULL with wr_stall=1 for 3 cycles -> wr_en/wr_addr/wr_data constant, readys low; write completes the cycle wr_stall drops.
REQ-035 reset pulsed while FULL (wr_addr=7) -> wr_en=0, wr_addr=0 immediately, before next clock edge.
REQ-036 ZERO_REG_FILTER_EN defined, req0 addr=0, req1 addr=9 same cycle -> both readys=1; only addr 9 written; last_grant=1.
REQ-037 Without the macro, same stimulus -> addr 0 written first, addr 9 next cycle.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time wins.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    last_grant_i,
  output logic [1:0] grant_o
);

  assign grant_o[0] = valid_i[0] & (~valid_i[1] | (last_grant_i == REQ1));
  assign grant_o[1] = valid_i[1] & (~valid_i[0] | (last_grant_i == REQ0));

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Merges two writeback requesters onto one register-file write port through a one-entry output stage.
// Optional feature: define ZERO_REG_FILTER_EN to absorb writes to register 0 without using the port.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_sel
);

  out_state_t        state_q, state_d;
  req_id_t           last_grant_q, last_grant_d;
  req_id_t           wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic       load_en;
  logic       load;
  logic [1:0] zero_ack;
  logic [1:0] arb_valid;
  logic [1:0] grant;

  assign load_en = (state_q == EMPTY) || !wr_stall;

`ifdef ZERO_REG_FILTER_EN
  // Register 0 is hardwired: acknowledge such writes at once and hide them from arbitration.
  assign zero_ack[0] = req0_valid && (req0_addr == '0);
  assign zero_ack[1] = req1_valid && (req1_addr == '0);
  assign arb_valid   = {req1_valid & ~zero_ack[1], req0_valid & ~zero_ack[0]};
`else
  assign zero_ack  = 2'b00;
  assign arb_valid = {req1_valid, req0_valid};
`endif

  rr_arb2 u_rr_arb2 (
    .valid_i      (arb_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign load       = load_en && (grant != 2'b00);
  assign req0_ready = !reset && ((load_en && grant[0]) || zero_ack[0]);
  assign req1_ready = !reset && ((load_en && grant[1]) || zero_ack[1]);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (load) begin
      state_d      = FULL;
      last_grant_d = grant[1] ? REQ1 : REQ0;
      wr_sel_d     = grant[1] ? REQ1 : REQ0;
      wr_addr_d    = grant[1] ? req1_addr : req0_addr;
      wr_data_d    = grant[1] ? req1_data : req0_data;
    end else if ((state_q == FULL) && !wr_stall) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= REQ1;
      wr_sel_q     <= REQ0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en   = (state_q == FULL);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_sel  = logic'(wr_sel_q);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter; expectations follow ZERO_REG_FILTER_EN when defined.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        wr_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_sel;

  int tests = 0;
  int fails = 0;

  regfile_wr_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_sel     (wr_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic sel);
    check({tag, ".wr_en"},   32'(wr_en),   32'(en));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(addr));
    check({tag, ".wr_data"}, wr_data,      data);
    check({tag, ".wr_sel"},  32'(wr_sel),  32'(sel));
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    #1;
    check({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    check({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 5'd1;
    req1_addr  = 5'd2;
    req0_data  = 32'h0;
    req1_data  = 32'h0;
    wr_stall   = 1'b0;

    // Reset state, readys held low even with both requesters valid.
    #1;
    check_port("reset", 1'b0, 5'd0, 32'h0, 1'b0);
    check_ready("reset", 1'b0, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Single request from req0: accept now, write visible one cycle later.
    tick();
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 32'hDEADBEEF;
    check_ready("single", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_port("single", 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
    tick();
    check_port("drain_hold", 1'b0, 5'd3, 32'hDEADBEEF, 1'b0);

    // Both valid from reset: alternate one write per cycle, req0 first.
    pulse_reset();
    req0_valid = 1'b1;
    req0_addr  = 5'd4;
    req0_data  = 32'hA0A0A0A0;
    req1_valid = 1'b1;
    req1_addr  = 5'd5;
    req1_data  = 32'hB1B1B1B1;
    check_ready("alt0", 1'b1, 1'b0);
    tick();
    check_port("alt1", 1'b1, 5'd4, 32'hA0A0A0A0, 1'b0);
    check_ready("alt1", 1'b0, 1'b1);
    tick();
    check_port("alt2", 1'b1, 5'd5, 32'hB1B1B1B1, 1'b1);
    tick();
    check_port("alt3", 1'b1, 5'd4, 32'hA0A0A0A0, 1'b0);
    tick();
    check_port("alt4", 1'b1, 5'd5, 32'hB1B1B1B1, 1'b1);

    // Stall for three cycles: port frozen, nobody accepted.
    wr_stall = 1'b1;
    check_ready("stall0", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_port($sformatf("stall%0d", i + 1), 1'b1, 5'd5, 32'hB1B1B1B1, 1'b1);
      check_ready($sformatf("stall%0d", i + 1), 1'b0, 1'b0);
    end
    wr_stall = 1'b0;
    check_ready("unstall", 1'b1, 1'b0);
    tick();
    check_port("unstall", 1'b1, 5'd4, 32'hA0A0A0A0, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check_port("empty", 1'b0, 5'd4, 32'hA0A0A0A0, 1'b0);

    // Asynchronous reset while holding addr 7 clears the port before any edge.
    req1_valid = 1'b1;
    req1_addr  = 5'd7;
    req1_data  = 32'h77777777;
    check_ready("full7", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_port("full7", 1'b1, 5'd7, 32'h77777777, 1'b1);
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_port("async_rst", 1'b0, 5'd0, 32'h0, 1'b0);
    check_ready("async_rst", 1'b0, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    check_port("post_rst", 1'b0, 5'd0, 32'h0, 1'b0);

    // Zero-address write from req0 racing a real write from req1.
    req0_valid = 1'b1;
    req0_addr  = 5'd0;
    req0_data  = 32'h11111111;
    req1_valid = 1'b1;
    req1_addr  = 5'd9;
    req1_data  = 32'h99999999;
`ifdef ZERO_REG_FILTER_EN
    check_ready("zero0", 1'b1, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_port("zero1", 1'b1, 5'd9, 32'h99999999, 1'b1);
    // Zero-address write is absorbed even while the port is stalled.
    wr_stall   = 1'b1;
    req0_valid = 1'b1;
    check_ready("zero_stall", 1'b1, 1'b0);
    tick();
    check_port("zero_stall", 1'b1, 5'd9, 32'h99999999, 1'b1);
    wr_stall   = 1'b0;
    req0_valid = 1'b0;
    tick();
`else
    check_ready("zero0", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_port("zero1", 1'b1, 5'd0, 32'h11111111, 1'b0);
    check_ready("zero1", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_port("zero2", 1'b1, 5'd9, 32'h99999999, 1'b1);
    tick();
`endif
    // last_grant is req1 here, so the next tie goes to req0.
    req0_valid = 1'b1;
    req0_addr  = 5'd2;
    req1_valid = 1'b1;
    req1_addr  = 5'd6;
    check_ready("tie_after", 1'b1, 1'b0);
    tick();
    check_port("tie_after", 1'b1, 5'd2, 32'h11111111, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
